prescaler_prog: RTL and testbench

Multi-channel programmable prescaler: each channel is a down-counter clocked by a shared clock-enable input that emits a single-cycle clock-enable pulse every (DIV+1) enabled cycles. It extends the fixed-divisor prescaler with per-channel runtime-loadable divisors, synchronous restart, run/freeze gating and a one-shot mode. It sits between the system clock-enable source and the Morse timing logic (dot/dash/gap timers), which need several independent, reprogrammable time bases.

---
 rtl/prescaler_prog_if.sv | 14 +
 rtl/prescaler_prog.sv | 41 ++++
 tb/tb_prescaler_prog.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/prescaler_prog_if.sv
// prescaler_prog_if: control and status bundle for the multi-channel programmable prescaler.
interface prescaler_prog_if #(parameter int CH = 2, parameter int W = 8);
    logic            ce;
    logic [CH-1:0]   run;
    logic [CH-1:0]   load;
    logic [CH*W-1:0] div_in;
    logic [CH-1:0]   restart;
    logic [CH-1:0]   oneshot;
    logic [CH-1:0]   ceo;
    logic [CH-1:0]   busy;
    logic [CH*W-1:0] cnt_out;
    modport master (output ce, run, load, div_in, restart, oneshot, input ceo, busy, cnt_out);
    modport slave (input ce, run, load, div_in, restart, oneshot, output ceo, busy, cnt_out);
endinterface

// File: rtl/prescaler_prog.sv
// prescaler_prog: per-channel down-counters that emit a one-cycle enable every DIV+1 enabled cycles.
module prescaler_prog #(
    parameter int CH = 2,
    parameter int W = 8,
    parameter int DEFAULT_DIV = 9
) (
    input logic clk,
    input logic rst,
    prescaler_prog_if.slave bus
);
    localparam logic [W-1:0] DEF = W'(DEFAULT_DIV);
    logic [CH-1:0][W-1:0] div, cnt, eff;
    logic [CH-1:0] ceo, busy;
    // a divisor loaded on a reload edge is used immediately
    always_comb
        for (int i = 0; i < CH; i++)
            eff[i] = bus.load[i] ? bus.div_in[i*W +: W] : div[i];
    always_ff @(posedge clk)
        for (int i = 0; i < CH; i++)
            if (rst) begin
                div[i] <= DEF;
                cnt[i] <= DEF;
                ceo[i] <= 1'b0;
                busy[i] <= 1'b1;
            end else begin
                if (bus.load[i]) div[i] <= bus.div_in[i*W +: W];
                if (bus.restart[i]) begin
                    cnt[i] <= eff[i];
                    ceo[i] <= 1'b0;
                    busy[i] <= 1'b1;
                end else if (busy[i] && bus.run[i] && bus.ce) begin
                    ceo[i] <= cnt[i] == '0;
                    cnt[i] <= cnt[i] == '0 ? eff[i] : cnt[i] - 1'b1;
                    if (cnt[i] == '0 && bus.oneshot[i]) busy[i] <= 1'b0;
                end else
                    ceo[i] <= 1'b0;
            end
    assign bus.ceo = ceo;
    assign bus.busy = busy;
    assign bus.cnt_out = cnt;
endmodule

// File: tb/tb_prescaler_prog.sv
// tb_prescaler_prog: directed phases queue expected pulses and state; a negedge monitor checks them.
module tb_prescaler_prog;
    logic clk = 1'b0;
    logic rst;
    int cyc = 0;
    int compared = 0;
    int mismatched = 0;
    typedef struct {int cyc; logic [1:0] ceo;} pulse_t;
    typedef struct {int cyc; logic [1:0] busy; logic [15:0] cnt;} st_t;
    pulse_t pq[$];
    st_t sq[$];
    pulse_t p;
    st_t s;

    prescaler_prog_if #(.CH(2), .W(8)) bus();
    prescaler_prog #(.CH(2), .W(8), .DEFAULT_DIV(9)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.ceo != 2'b00) begin
            compared++;
            if (pq.size() == 0) begin
                mismatched++;
                $display("FAIL pulse: got ceo=%b at cycle %0d, required no pulse", bus.ceo, cyc);
            end else begin
                p = pq.pop_front();
                if (p.cyc != cyc || p.ceo != bus.ceo) begin
                    mismatched++;
                    $display("FAIL pulse: got ceo=%b at cycle %0d, required ceo=%b at cycle %0d", bus.ceo, cyc, p.ceo, p.cyc);
                end
            end
        end
        if (sq.size() != 0 && sq[0].cyc == cyc) begin
            s = sq.pop_front();
            compared++;
            if (bus.busy != s.busy || bus.cnt_out != s.cnt) begin
                mismatched++;
                $display("FAIL state@%0d: got busy=%b cnt=%h, required busy=%b cnt=%h", cyc, bus.busy, bus.cnt_out, s.busy, s.cnt);
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.ce = 1'b0;
        bus.run = 2'b00;
        bus.load = 2'b00;
        bus.restart = 2'b00;
        bus.oneshot = 2'b00;
        bus.div_in = 16'h0000;
        sq.push_back('{2, 2'b11, {8'd9, 8'd9}});
        step(2);
        rst = 1'b0;
        bus.ce = 1'b1;
        bus.run = 2'b11;
        sq.push_back('{3, 2'b11, {8'd8, 8'd8}});
        sq.push_back('{12, 2'b11, {8'd9, 8'd9}});
        pq.push_back('{12, 2'b11});
        pq.push_back('{22, 2'b11});
        pq.push_back('{32, 2'b11});
        step(31);
        // ce every third clock with div=2
        bus.div_in = {8'd2, 8'd2};
        bus.load = 2'b11;
        bus.restart = 2'b11;
        bus.ce = 1'b0;
        step(1);
        bus.load = 2'b00;
        bus.restart = 2'b00;
        pq.push_back('{41, 2'b11});
        pq.push_back('{50, 2'b11});
        pq.push_back('{59, 2'b11});
        sq.push_back('{45, 2'b11, {8'd1, 8'd1}});
        for (int k = 0; k < 27; k++) begin
            bus.ce = (k % 3 == 0);
            step(1);
        end
        bus.ce = 1'b1;
        bus.div_in = {8'd6, 8'd9};
        bus.load = 2'b11;
        bus.restart = 2'b11;
        step(1);
        bus.load = 2'b00;
        bus.restart = 2'b00;
        sq.push_back('{66, 2'b11, {8'd2, 8'd5}});
        sq.push_back('{72, 2'b11, {8'd3, 8'd3}});
        pq.push_back('{69, 2'b10});
        pq.push_back('{72, 2'b01});
        pq.push_back('{76, 2'b11});
        pq.push_back('{80, 2'b01});
        pq.push_back('{83, 2'b10});
        pq.push_back('{84, 2'b01});
        step(4);
        bus.div_in = {8'd6, 8'd3};
        bus.load = 2'b01;
        step(1);
        bus.load = 2'b00;
        step(18);
        // load and restart together on channel 1 with divisor 0
        bus.div_in = 16'h0000;
        bus.load = 2'b10;
        bus.restart = 2'b10;
        sq.push_back('{86, 2'b11, {8'd0, 8'd1}});
        step(1);
        bus.load = 2'b00;
        bus.restart = 2'b00;
        pq.push_back('{87, 2'b10});
        pq.push_back('{88, 2'b11});
        pq.push_back('{89, 2'b10});
        pq.push_back('{90, 2'b10});
        pq.push_back('{91, 2'b10});
        pq.push_back('{92, 2'b11});
        pq.push_back('{95, 2'b10});
        step(6);
        bus.ce = 1'b0;
        step(2);
        bus.ce = 1'b1;
        step(1);
        // one-shot on channel 0, channel 1 frozen
        bus.run = 2'b01;
        bus.div_in = 16'h0004;
        bus.load = 2'b01;
        bus.restart = 2'b01;
        bus.oneshot = 2'b01;
        pq.push_back('{101, 2'b01});
        sq.push_back('{102, 2'b10, {8'd0, 8'd4}});
        sq.push_back('{151, 2'b10, {8'd0, 8'd4}});
        step(1);
        bus.load = 2'b00;
        bus.restart = 2'b00;
        step(55);
        bus.restart = 2'b01;
        sq.push_back('{152, 2'b11, {8'd0, 8'd4}});
        sq.push_back('{165, 2'b10, {8'd0, 8'd4}});
        pq.push_back('{157, 2'b01});
        step(1);
        bus.restart = 2'b00;
        step(13);
        bus.oneshot = 2'b00;
        bus.div_in = 16'h0009;
        bus.load = 2'b01;
        bus.restart = 2'b01;
        step(1);
        bus.load = 2'b00;
        bus.restart = 2'b00;
        step(3);
        bus.run = 2'b00;
        sq.push_back('{176, 2'b11, {8'd0, 8'd6}});
        step(7);
        bus.run = 2'b01;
        pq.push_back('{183, 2'b01});
        step(7);
        bus.div_in = 16'h0003;
        bus.load = 2'b01;
        bus.restart = 2'b01;
        step(1);
        bus.load = 2'b00;
        bus.restart = 2'b00;
        step(1);
        rst = 1'b1;
        sq.push_back('{186, 2'b11, {8'd9, 8'd9}});
        step(1);
        rst = 1'b0;
        bus.run = 2'b11;
        pq.push_back('{196, 2'b11});
        step(12);
        compared++;
        if (pq.size() != 0 || sq.size() != 0) begin
            mismatched++;
            $display("FAIL leftover: got %0d pulses and %0d states unseen, required 0", pq.size(), sq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
